// File: rtl/traffic_defs.sv
// traffic_defs: definitions shared by the traffic signal controller and
// its upstream sensor conditioner.
//   light_t      2-bit light code (RED=0, YELLOW=1, GREEN=2)
//   TRUE/FALSE   single-bit boolean constants
//   DEF_*        default timing/width parameters
//   clog2_min1   counter width helper that never returns 0
package traffic_defs;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 4;
  localparam int DEF_DRAIN_CYCLES    = 8;

  // A counter that only ever holds 0 still needs a 1-bit register.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/car_sensor_conditioner_debounce.sv
// sensor_debounce: two-flop synchroniser, debouncer and rising-edge detector
// for the raw loop-detector level.
// Ports:
//   i_clock       system clock, posedge
//   i_clear       synchronous active-high reset
//   i_sensor_raw  asynchronous raw sensor level
//   o_arrival     one-cycle pulse on a debounced rising edge
//   o_deb         debounced sensor level
module sensor_debounce
  import traffic_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_sensor_raw,
  output logic o_arrival,
  output logic o_deb
);

  localparam int DW = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LP_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_q;
  logic [DW-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sensor_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      // Any return to agreement restarts the count, so a level must differ
      // for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  assign o_arrival = r_deb & ~r_deb_q;
  assign o_deb     = r_deb;

endmodule

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: conditions the country-road vehicle sensor and
// keeps a saturating count of waiting vehicles; the queue drains one vehicle
// per DRAIN_CYCLES cycles of country GREEN.
// Ports:
//   clock       system clock, posedge
//   clear       synchronous active-high reset
//   sensor_raw  asynchronous raw loop-detector level
//   cntry       country light code from the controller
//   X           vehicle(s) waiting (count != 0)
//   count       number of queued vehicles
//   overflow    sticky: an arrival was lost because count was saturated
//
// state   | meaning
// IDLE    | count == 0
// WAITING | count > 0, country not GREEN
// SERVING | count > 0, country GREEN, drain timer running
// The state is implied by count and cntry; there is no state register.
module car_sensor_conditioner
  import traffic_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sensor_raw,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int TW = clog2_min1(DRAIN_CYCLES);
  localparam logic [TW-1:0] LP_DRAIN_LAST = TW'(DRAIN_CYCLES - 1);

  logic             w_arrival;
  logic             w_deb;
  logic             w_unused_deb;
  logic             w_serving;
  logic             w_drain;
  logic [CNT_W-1:0] r_count;
  logic [TW-1:0]    r_drain_tmr;
  logic             r_overflow;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clock      (clock),
    .i_clear      (clear),
    .i_sensor_raw (sensor_raw),
    .o_arrival    (w_arrival),
    .o_deb        (w_deb)
  );

  // The debounced level itself is not needed here; only its rising edge is.
  assign w_unused_deb = w_deb;

  assign w_serving = (cntry == GREEN) && (r_count != '0);
  assign w_drain   = w_serving && (r_drain_tmr == LP_DRAIN_LAST);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count     <= '0;
      r_drain_tmr <= '0;
      r_overflow  <= 1'b0;
    end else begin
      // YELLOW or an empty queue restarts the drain period from scratch.
      if (!w_serving || w_drain) begin
        r_drain_tmr <= '0;
      end else begin
        r_drain_tmr <= r_drain_tmr + TW'(1);
      end

      // A simultaneous arrival and release cancel out.
      case ({w_arrival, w_drain})
        2'b10: begin
          if (r_count == '1) begin
            r_overflow <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign X        = (r_count != '0);
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
